// File: rtl/sram_bist_pkg.sv
// Shared types and March C- element tables for the two-port SRAM BIST sequencer.
package sram_bist_pkg;

    typedef enum logic [2:0] {M0, M1, M2, M3, M4, M5} march_elem_t;
    typedef enum logic [1:0] {NOP, RD, WR} op_t;
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;

    localparam int C_NUM_ELEM = 6;

    // 1 = element walks the address space downwards
    localparam logic C_ELEM_DIR [C_NUM_ELEM] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    localparam op_t C_ELEM_OPS [C_NUM_ELEM][2] = '{
        '{WR, NOP}, '{RD, WR}, '{RD, WR}, '{RD, WR}, '{RD, WR}, '{RD, NOP}
    };

    // {read polarity, write polarity}: 0 = background D0, 1 = complement D1
    localparam logic [1:0] C_ELEM_DATA [C_NUM_ELEM] = '{2'b00, 2'b01, 2'b10, 2'b01, 2'b10, 2'b00};

endpackage

// File: rtl/sram_bist_addr_gen.sv
// Address counter for the March sequencer: loadable, steps up or down, flags the
// terminal address of the current direction (all-ones going up, zero going down).
module sram_bist_addr_gen #(
    parameter int P_ADDR_WIDTH = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [P_ADDR_WIDTH-1:0] load_val,
    input  logic                    step,
    input  logic                    down,
    output logic [P_ADDR_WIDTH-1:0] addr,
    output logic                    at_last
);

    always_ff @(posedge clk) begin
        if (rst)
            addr <= '0;
        else if (load)
            addr <= load_val;
        else if (step)
            addr <= down ? addr - 1'b1 : addr + 1'b1;
    end

    assign at_last = down ? (addr == '0) : (addr == '1);

endmodule

// File: rtl/sram_2p_march_bist_ctrl.sv
// March C- BIST sequencer driving the BIST port of one selected side of a 2-port SRAM,
// with a one-stage read-compare pipe and sticky first-fail diagnostics.
module sram_2p_march_bist_ctrl
    import sram_bist_pkg::*;
#(
    parameter int                      P_ADDR_WIDTH = 10,
    parameter int                      P_DATA_WIDTH = 32,
    parameter logic [P_DATA_WIDTH-1:0] P_BG         = '0
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    START,
    input  logic                    PORT_SEL,
    output logic                    BUSY,
    output logic                    DONE,
    output logic                    FAIL,
    output logic [P_ADDR_WIDTH-1:0] FAIL_ADDR,
    output logic [2:0]              FAIL_ELEM,
    output logic [P_DATA_WIDTH-1:0] FAIL_MASK,
    output logic                    A_BIST_EN,
    output logic                    A_BIST_MEN,
    output logic                    A_BIST_WEN,
    output logic                    A_BIST_REN,
    output logic [P_ADDR_WIDTH-1:0] A_BIST_ADDR,
    output logic [P_DATA_WIDTH-1:0] A_BIST_DIN,
    output logic [P_DATA_WIDTH-1:0] A_BIST_BM,
    input  logic [P_DATA_WIDTH-1:0] A_DOUT,
    output logic                    B_BIST_EN,
    output logic                    B_BIST_MEN,
    output logic                    B_BIST_WEN,
    output logic                    B_BIST_REN,
    output logic [P_ADDR_WIDTH-1:0] B_BIST_ADDR,
    output logic [P_DATA_WIDTH-1:0] B_BIST_DIN,
    output logic [P_DATA_WIDTH-1:0] B_BIST_BM,
    input  logic [P_DATA_WIDTH-1:0] B_DOUT
);

    // state    | meaning
    // ST_IDLE  | waiting for START
    // ST_RUN   | one March op per cycle on the selected port
    // ST_DRAIN | no op; compares the final M5 read
    // ST_DONE  | DONE pulse, results stable
    state_t                    state, nxt_state;
    march_elem_t               elem, nxt_elem;
    logic                      phase, nxt_phase;
    logic                      sel, nxt_sel;
    logic                      nxt_busy, nxt_a, nxt_b, last_op;
    op_t                       nxt_op;
    logic                      cnt_load, cnt_step, cnt_last;
    logic [P_ADDR_WIDTH-1:0]   cnt_val, cnt_addr;
    logic [P_DATA_WIDTH-1:0]   din_q, rd_data, miscmp;
    logic                      pipe_vld;
    logic [P_DATA_WIDTH-1:0]   pipe_exp;
    logic [P_ADDR_WIDTH-1:0]   pipe_addr;
    march_elem_t               pipe_elem;

    function automatic logic [P_DATA_WIDTH-1:0] pattern(input logic pol);
        return pol ? ~P_BG : P_BG;
    endfunction

    sram_bist_addr_gen #(.P_ADDR_WIDTH(P_ADDR_WIDTH)) u_addr_gen (
        .clk      (CLK),
        .rst      (RST),
        .load     (cnt_load),
        .load_val (cnt_val),
        .step     (cnt_step),
        .down     (C_ELEM_DIR[elem]),
        .addr     (cnt_addr),
        .at_last  (cnt_last)
    );

    assign last_op     = phase || (C_ELEM_OPS[elem][1] == NOP);
    assign A_BIST_ADDR = cnt_addr;
    assign B_BIST_ADDR = cnt_addr;
    assign A_BIST_DIN  = din_q;
    assign B_BIST_DIN  = din_q;
    assign rd_data     = sel ? B_DOUT : A_DOUT;
    assign miscmp      = rd_data ^ pipe_exp;

    // Decides the op to present next; the counter follows the same decision.
    always_comb begin
        nxt_state = state;
        nxt_elem  = elem;
        nxt_phase = phase;
        cnt_load  = 1'b0;
        cnt_step  = 1'b0;
        cnt_val   = '0;
        unique case (state)
            ST_IDLE: begin
                if (START) begin
                    nxt_state = ST_RUN;
                    nxt_elem  = M0;
                    nxt_phase = 1'b0;
                    cnt_load  = 1'b1;
                end
            end
            ST_RUN: begin
                if (!last_op) begin
                    nxt_phase = 1'b1;
                end else if (!cnt_last) begin
                    nxt_phase = 1'b0;
                    cnt_step  = 1'b1;
                end else if (elem == M5) begin
                    nxt_state = ST_DRAIN;
                    nxt_phase = 1'b0;
                    cnt_load  = 1'b1;
                end else begin
                    nxt_elem  = march_elem_t'(elem + 3'd1);
                    nxt_phase = 1'b0;
                    cnt_load  = 1'b1;
                    cnt_val   = C_ELEM_DIR[nxt_elem] ? {P_ADDR_WIDTH{1'b1}} : '0;
                end
            end
            ST_DRAIN: nxt_state = ST_DONE;
            default:  nxt_state = ST_IDLE;
        endcase
        nxt_sel  = (state == ST_IDLE && START) ? PORT_SEL : sel;
        nxt_busy = (nxt_state == ST_RUN) || (nxt_state == ST_DRAIN);
        nxt_op   = (nxt_state == ST_RUN) ? C_ELEM_OPS[nxt_elem][nxt_phase] : NOP;
        nxt_a    = nxt_busy && !nxt_sel;
        nxt_b    = nxt_busy && nxt_sel;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= ST_IDLE;
            elem       <= M0;
            phase      <= 1'b0;
            sel        <= 1'b0;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
            A_BIST_EN  <= 1'b0;
            A_BIST_MEN <= 1'b0;
            A_BIST_WEN <= 1'b0;
            A_BIST_REN <= 1'b0;
            A_BIST_BM  <= '0;
            B_BIST_EN  <= 1'b0;
            B_BIST_MEN <= 1'b0;
            B_BIST_WEN <= 1'b0;
            B_BIST_REN <= 1'b0;
            B_BIST_BM  <= '0;
            din_q      <= '0;
            pipe_vld   <= 1'b0;
            pipe_exp   <= '0;
            pipe_addr  <= '0;
            pipe_elem  <= M0;
            FAIL       <= 1'b0;
            FAIL_ADDR  <= '0;
            FAIL_ELEM  <= '0;
            FAIL_MASK  <= '0;
        end else begin
            state      <= nxt_state;
            elem       <= nxt_elem;
            phase      <= nxt_phase;
            sel        <= nxt_sel;
            BUSY       <= nxt_busy;
            DONE       <= (nxt_state == ST_DONE);
            A_BIST_EN  <= nxt_a;
            A_BIST_MEN <= nxt_a && (nxt_op != NOP);
            A_BIST_WEN <= nxt_a && (nxt_op == WR);
            A_BIST_REN <= nxt_a && (nxt_op == RD);
            A_BIST_BM  <= {P_DATA_WIDTH{nxt_a}};
            B_BIST_EN  <= nxt_b;
            B_BIST_MEN <= nxt_b && (nxt_op != NOP);
            B_BIST_WEN <= nxt_b && (nxt_op == WR);
            B_BIST_REN <= nxt_b && (nxt_op == RD);
            B_BIST_BM  <= {P_DATA_WIDTH{nxt_b}};
            din_q      <= (nxt_op == WR) ? pattern(C_ELEM_DATA[nxt_elem][0]) : '0;
            // Capture what the read presented this cycle should return next cycle
            pipe_vld   <= A_BIST_REN || B_BIST_REN;
            pipe_exp   <= pattern(C_ELEM_DATA[elem][1]);
            pipe_addr  <= cnt_addr;
            pipe_elem  <= elem;
            if (state == ST_IDLE && START) begin
                FAIL      <= 1'b0;
                FAIL_ADDR <= '0;
                FAIL_ELEM <= '0;
                FAIL_MASK <= '0;
            end else if (pipe_vld && (miscmp != '0)) begin
                FAIL      <= 1'b1;
                FAIL_MASK <= FAIL_MASK | miscmp;
                if (!FAIL) begin
                    FAIL_ADDR <= pipe_addr;
                    FAIL_ELEM <= pipe_elem;
                end
            end
        end
    end

endmodule
